muldiv_sched: RTL



---
 rtl/muldiv_sched_pkg.sv | 59 +++++
 rtl/muldiv_sched_md_arith.sv | 57 +++++
 rtl/muldiv_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared MIPS decode helpers for the multiply/divide sequencer, hazard unit and decoder:
// SPECIAL funct codes for the HI/LO instruction group and instruction field extractors.
package muldiv_sched_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;

   // Encoding matches funct[1:0] of the MD_START group.
   typedef enum logic [1:0] {
      MdMult  = 2'b00,
      MdMultu = 2'b01,
      MdDiv   = 2'b10,
      MdDivu  = 2'b11
   } md_op_e;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } md_state_e;

   function automatic logic [5:0] ir_op(input logic [31:0] ir);
      return ir[31:26];
   endfunction

   function automatic logic [4:0] ir_rs(input logic [31:0] ir);
      return ir[25:21];
   endfunction

   function automatic logic [4:0] ir_rt(input logic [31:0] ir);
      return ir[20:16];
   endfunction

   function automatic logic [4:0] ir_rd(input logic [31:0] ir);
      return ir[15:11];
   endfunction

   function automatic logic [5:0] ir_funct(input logic [31:0] ir);
      return ir[5:0];
   endfunction

   function automatic logic is_md_start(input logic [31:0] ir);
      return (ir_op(ir) == OP_SPECIAL) &&
             (ir_funct(ir) inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
   endfunction

   function automatic logic is_md_access(input logic [31:0] ir);
      return (ir_op(ir) == OP_SPECIAL) &&
             (ir_funct(ir) inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
   endfunction

endpackage

// File: rtl/muldiv_sched_md_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one MD_START op,
// including signed fix-ups, divide-by-zero and the INT_MIN / -1 overflow case.
module md_arith
   import muldiv_sched_pkg::*;
(
   input  md_op_e      op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        signed_div;
   logic        rs_neg;
   logic        rt_neg;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic [31:0] dvs_safe;
   logic [31:0] quo;
   logic [31:0] rem;

   always_comb begin
      // Low 64 bits of the sign-extended product equal the signed 32x32 product.
      prod_s     = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
      prod_u     = {32'h0, rs_i} * {32'h0, rt_i};
      signed_div = (op_i == MdDiv);
      rs_neg     = signed_div & rs_i[31];
      rt_neg     = signed_div & rt_i[31];
      dvd        = rs_neg ? -rs_i : rs_i;
      dvs        = rt_neg ? -rt_i : rt_i;
      // Keep the shared unsigned divider away from a zero divisor; result is overridden.
      dvs_safe   = (dvs == 32'h0) ? 32'h1 : dvs;
      quo        = dvd / dvs_safe;
      rem        = dvd % dvs_safe;
      hi_o       = 32'h0;
      lo_o       = 32'h0;
      case (op_i)
         MdMult:  {hi_o, lo_o} = prod_s;
         MdMultu: {hi_o, lo_o} = prod_u;
         default: begin
            if (rt_i == 32'h0) begin
               lo_o = 32'hFFFF_FFFF;
               hi_o = rs_i;
            end else if (signed_div && rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
               lo_o = 32'h8000_0000;
               hi_o = 32'h0;
            end else begin
               lo_o = (rs_neg ^ rt_neg) ? -quo : quo;
               hi_o = rs_neg ? -rem : rem;
            end
         end
      endcase
   end

endmodule

// File: rtl/muldiv_sched.sv
// E-stage multiply/divide sequencer: launches mult/div, counts a fixed latency, commits HI/LO,
// and requests a pipeline stall for any HI/LO instruction in D while the unit is occupied.
module muldiv_sched
   import muldiv_sched_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IR_D,
   input  logic [31:0] IR_E,
   input  logic [31:0] RS_E,
   input  logic [31:0] RT_E,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        stall_md
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;

   md_op_e      op_e;
   logic        start;
   logic        mthi_e;
   logic        mtlo_e;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   assign op_e   = md_op_e'(IR_E[1:0]);
   assign start  = is_md_start(IR_E) && (state_q == StIdle);
   assign mthi_e = (ir_op(IR_E) == OP_SPECIAL) && (ir_funct(IR_E) == FN_MTHI);
   assign mtlo_e = (ir_op(IR_E) == OP_SPECIAL) && (ir_funct(IR_E) == FN_MTLO);

   md_arith u_md_arith (
      .op_i (op_e),
      .rs_i (RS_E),
      .rt_i (RT_E),
      .hi_o (res_hi),
      .lo_o (res_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               cnt_d     = op_e[1] ? DIV_CNT : MULT_CNT;
               state_d   = StBusy;
            end else begin
               if (mthi_e) hi_d = RS_E;
               if (mtlo_e) lo_d = RS_E;
            end
         end
         StBusy: begin
            // A new MD_START arriving here is ignored; only the counter advances.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         hi_q      <= 32'h0;
         lo_q      <= 32'h0;
         pend_hi_q <= 32'h0;
         pend_lo_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign HI       = hi_q;
   assign LO       = lo_q;
   assign busy     = (state_q == StBusy);
   assign stall_md = (is_md_start(IR_D) || is_md_access(IR_D)) && (busy || start);

endmodule
